// File: rtl/bru_bpu.sv
// Branch resolution unit with a direct-mapped BTB predictor and saturating
// performance counters. Prediction and resolution are combinational; table
// and counter updates land on the next rising edge.
module bru_bpu #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned IDX_BITS  = 6,
  parameter int unsigned TAG_BITS  = 8,
  parameter int unsigned CNT_BITS  = 2,
  parameter int unsigned PERF_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN-1:0]      if_pc,
  output logic                 pred_taken,
  output logic [XLEN-1:0]      pred_target,
  input  logic                 ex_valid,
  input  logic [XLEN-1:0]      ex_pc,
  input  logic [XLEN-1:0]      ex_rs1_data,
  input  logic [XLEN-1:0]      ex_rs2_data,
  input  logic                 ex_is_br,
  input  logic                 ex_is_uncbr,
  input  logic [2:0]           ex_func3,
  input  logic [XLEN-1:0]      ex_target,
  input  logic                 ex_pred_taken,
  input  logic [XLEN-1:0]      ex_pred_target,
  output logic                 ex_taken,
  output logic                 mispredict,
  output logic [XLEN-1:0]      redirect_pc,
  output logic [PERF_BITS-1:0] perf_br_cnt,
  output logic [PERF_BITS-1:0] perf_miss_cnt
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;
  localparam logic [CNT_BITS-1:0] CTR_WEAK = CNT_BITS'(1) << (CNT_BITS - 1);

  logic                 r_valid  [ENTRIES];
  logic [TAG_BITS-1:0]  r_tag    [ENTRIES];
  logic [XLEN-1:0]      r_target [ENTRIES];
  logic [CNT_BITS-1:0]  r_ctr    [ENTRIES];
  logic [PERF_BITS-1:0] r_perf_br;
  logic [PERF_BITS-1:0] r_perf_miss;

  logic [IDX_BITS-1:0]  w_if_idx;
  logic [TAG_BITS-1:0]  w_if_tag;
  logic                 w_if_hit;
  logic [XLEN-1:0]      w_if_seq;
  logic [IDX_BITS-1:0]  w_ex_idx;
  logic [TAG_BITS-1:0]  w_ex_tag;
  logic                 w_ex_hit;
  logic [XLEN-1:0]      w_ex_seq;
  logic                 w_cond;
  logic                 w_ex_taken;
  logic                 w_mispredict;
  logic                 w_upd;
  logic                 w_wr_en;
  logic [CNT_BITS-1:0]  w_wr_ctr;
  logic [XLEN-1:0]      w_wr_target;
  logic                 w_unused_pc_bits;

  assign w_unused_pc_bits = ^{if_pc, ex_pc};

  // ---------------- IF-stage lookup ----------------
  assign w_if_idx = if_pc[IDX_BITS+1:2];
  assign w_if_tag = if_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign w_if_seq = if_pc + XLEN'(4);

  always_comb begin
    pred_taken  = w_if_hit && r_ctr[w_if_idx][CNT_BITS-1];
    pred_target = pred_taken ? r_target[w_if_idx] : w_if_seq;
  end

  // ---------------- EX-stage resolution ----------------
  always_comb begin
    w_cond = 1'b0;
    case (ex_func3)
      3'b000:  w_cond = (ex_rs1_data == ex_rs2_data);
      3'b001:  w_cond = (ex_rs1_data != ex_rs2_data);
      3'b100:  w_cond = ($signed(ex_rs1_data) <  $signed(ex_rs2_data));
      3'b101:  w_cond = ($signed(ex_rs1_data) >= $signed(ex_rs2_data));
      3'b110:  w_cond = (ex_rs1_data <  ex_rs2_data);
      3'b111:  w_cond = (ex_rs1_data >= ex_rs2_data);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_ex_seq     = ex_pc + XLEN'(4);
  assign w_ex_taken   = ex_valid & (ex_is_uncbr | (ex_is_br & w_cond));
  assign w_mispredict = ex_valid & ((w_ex_taken != ex_pred_taken) |
                                    (w_ex_taken & (ex_pred_target != ex_target)));

  always_comb begin
    ex_taken   = w_ex_taken;
    mispredict = w_mispredict;
    if (!ex_valid)       redirect_pc = '0;
    else if (w_ex_taken) redirect_pc = ex_target;
    else                 redirect_pc = w_ex_seq;
  end

  // ---------------- BTB update selection ----------------
  assign w_ex_idx = ex_pc[IDX_BITS+1:2];
  assign w_ex_tag = ex_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_upd    = ex_valid & (ex_is_br | ex_is_uncbr);

  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_ctr    = r_ctr[w_ex_idx];
    w_wr_target = r_target[w_ex_idx];
    if (w_upd) begin
      if (w_ex_hit) begin
        w_wr_en = 1'b1;
        if (ex_is_uncbr) begin
          w_wr_ctr    = '1;
          w_wr_target = ex_target;
        end else if (w_ex_taken) begin
          if (r_ctr[w_ex_idx] != '1) w_wr_ctr = r_ctr[w_ex_idx] + CNT_BITS'(1);
          w_wr_target = ex_target;
        end else begin
          if (r_ctr[w_ex_idx] != '0) w_wr_ctr = r_ctr[w_ex_idx] - CNT_BITS'(1);
        end
      end else if (w_ex_taken) begin
        // Miss allocations start weakly taken; jumps start saturated.
        w_wr_en     = 1'b1;
        w_wr_target = ex_target;
        w_wr_ctr    = ex_is_uncbr ? '1 : CTR_WEAK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= '0;
      end
    end else if (w_wr_en) begin
      r_valid[w_ex_idx]  <= 1'b1;
      r_tag[w_ex_idx]    <= w_ex_tag;
      r_target[w_ex_idx] <= w_wr_target;
      r_ctr[w_ex_idx]    <= w_wr_ctr;
    end
  end

  // ---------------- Performance counters ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_br   <= '0;
      r_perf_miss <= '0;
    end else if (w_upd) begin
      if (r_perf_br != '1) r_perf_br <= r_perf_br + PERF_BITS'(1);
      if (w_mispredict && (r_perf_miss != '1)) r_perf_miss <= r_perf_miss + PERF_BITS'(1);
    end
  end

  assign perf_br_cnt   = r_perf_br;
  assign perf_miss_cnt = r_perf_miss;

endmodule

// File: tb/tb_bru_bpu.sv
// Directed self-checking bench for bru_bpu: default-parameter instance plus a
// 4-bit performance-counter instance sharing the same stimulus.
module tb_bru_bpu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data;
  logic        ex_is_br, ex_is_uncbr;
  logic [2:0]  ex_func3;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;

  logic        pred_taken, ex_taken, mispredict;
  logic [31:0] pred_target, redirect_pc, perf_br_cnt, perf_miss_cnt;

  logic        p_pred_taken, p_ex_taken, p_mispredict;
  logic [31:0] p_pred_target, p_redirect_pc;
  logic [3:0]  p_perf_br_cnt, p_perf_miss_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bru_bpu dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_is_br(ex_is_br), .ex_is_uncbr(ex_is_uncbr), .ex_func3(ex_func3),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target),
    .ex_taken(ex_taken), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .perf_br_cnt(perf_br_cnt), .perf_miss_cnt(perf_miss_cnt)
  );

  bru_bpu #(.PERF_BITS(4)) dut_p (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_taken(p_pred_taken), .pred_target(p_pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_is_br(ex_is_br), .ex_is_uncbr(ex_is_uncbr), .ex_func3(ex_func3),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target),
    .ex_taken(p_ex_taken), .mispredict(p_mispredict), .redirect_pc(p_redirect_pc),
    .perf_br_cnt(p_perf_br_cnt), .perf_miss_cnt(p_perf_miss_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] pc, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic br, input logic unc,
                        input logic [2:0] f3, input logic [31:0] tgt,
                        input logic ptk, input logic [31:0] ptgt);
    ex_valid = v; ex_pc = pc; ex_rs1_data = rs1; ex_rs2_data = rs2;
    ex_is_br = br; ex_is_uncbr = unc; ex_func3 = f3; ex_target = tgt;
    ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  task automatic clear_ex();
    ex_valid = 1'b0; ex_is_br = 1'b0; ex_is_uncbr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_pc = 32'h0; clear_ex();
    set_ex(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 32'h0);
    tick();
    rst = 1'b0; if_pc = 32'h100;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %b expected 0", pred_taken); end
    checks++; if (pred_target !== 32'h104) begin errors++; $display("FAIL reset_pred_target: got %h expected 00000104", pred_target); end
    checks++; if (perf_br_cnt !== 32'd0) begin errors++; $display("FAIL reset_perf_br: got %0d expected 0", perf_br_cnt); end
    checks++; if (perf_miss_cnt !== 32'd0) begin errors++; $display("FAIL reset_perf_miss: got %0d expected 0", perf_miss_cnt); end
  endtask

  task automatic test_train_taken();
    set_ex(1'b1, 32'h100, 32'd1, 32'd1, 1'b1, 1'b0, 3'b000, 32'h140, 1'b0, 32'h104);
    #1;
    checks++; if (ex_taken !== 1'b1) begin errors++; $display("FAIL beq_taken: got %b expected 1", ex_taken); end
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL beq_mispredict: got %b expected 1", mispredict); end
    checks++; if (redirect_pc !== 32'h140) begin errors++; $display("FAIL beq_redirect: got %h expected 00000140", redirect_pc); end
    tick();
    clear_ex(); if_pc = 32'h100;
    #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_pred_taken: got %b expected 1", pred_taken); end
    checks++; if (pred_target !== 32'h140) begin errors++; $display("FAIL alloc_pred_target: got %h expected 00000140", pred_target); end
    checks++; if (perf_br_cnt !== 32'd1) begin errors++; $display("FAIL train_perf_br: got %0d expected 1", perf_br_cnt); end
    checks++; if (perf_miss_cnt !== 32'd1) begin errors++; $display("FAIL train_perf_miss: got %0d expected 1", perf_miss_cnt); end
  endtask

  task automatic test_back_to_back_untrain();
    // ctr 10 -> 01
    set_ex(1'b1, 32'h100, 32'd1, 32'd2, 1'b1, 1'b0, 3'b000, 32'h140, 1'b1, 32'h140);
    #1;
    checks++; if (ex_taken !== 1'b0) begin errors++; $display("FAIL nt_taken: got %b expected 0", ex_taken); end
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL nt_mispredict: got %b expected 1", mispredict); end
    checks++; if (redirect_pc !== 32'h104) begin errors++; $display("FAIL nt_redirect: got %h expected 00000104", redirect_pc); end
    tick();
    clear_ex(); if_pc = 32'h100;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL ctr01_pred: got %b expected 0", pred_taken); end
    checks++; if (pred_target !== 32'h104) begin errors++; $display("FAIL ctr01_target: got %h expected 00000104", pred_target); end
    // ctr 01 -> 00, correctly predicted
    set_ex(1'b1, 32'h100, 32'd1, 32'd2, 1'b1, 1'b0, 3'b000, 32'h140, 1'b0, 32'h104);
    #1;
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL nt2_mispredict: got %b expected 0", mispredict); end
    tick();
    // ctr 00 -> 01: still not taken proves the counter had reached 00
    set_ex(1'b1, 32'h100, 32'd3, 32'd3, 1'b1, 1'b0, 3'b000, 32'h140, 1'b0, 32'h104);
    tick();
    clear_ex();
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL ctr00_inc_pred: got %b expected 0", pred_taken); end
    checks++; if (perf_br_cnt !== 32'd4) begin errors++; $display("FAIL untrain_perf_br: got %0d expected 4", perf_br_cnt); end
    checks++; if (perf_miss_cnt !== 32'd3) begin errors++; $display("FAIL untrain_perf_miss: got %0d expected 3", perf_miss_cnt); end
  endtask

  task automatic test_conditions();
    tick();
    set_ex(1'b1, 32'h800, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 3'b100, 32'h900, 1'b0, 32'h804);
    #1; checks++; if (ex_taken !== 1'b1) begin errors++; $display("FAIL blt_signed: got %b expected 1", ex_taken); end
    ex_func3 = 3'b110;
    #1; checks++; if (ex_taken !== 1'b0) begin errors++; $display("FAIL bltu: got %b expected 0", ex_taken); end
    ex_func3 = 3'b010;
    #1; checks++; if (ex_taken !== 1'b0) begin errors++; $display("FAIL func3_010: got %b expected 0", ex_taken); end
    ex_func3 = 3'b101;
    #1; checks++; if (ex_taken !== 1'b0) begin errors++; $display("FAIL bge_signed: got %b expected 0", ex_taken); end
    ex_func3 = 3'b111;
    #1; checks++; if (ex_taken !== 1'b1) begin errors++; $display("FAIL bgeu: got %b expected 1", ex_taken); end
    ex_func3 = 3'b110; ex_is_br = 1'b0; ex_is_uncbr = 1'b1;
    #1; checks++; if (ex_taken !== 1'b1) begin errors++; $display("FAIL uncbr_taken: got %b expected 1", ex_taken); end
    clear_ex();
    tick();
    set_ex(1'b1, 32'h800, 32'h0, 32'h0, 1'b0, 1'b1, 3'b000, 32'h300, 1'b1, 32'h200);
    #1; checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL target_mismatch: got %b expected 1", mispredict); end
    ex_pred_target = 32'h300;
    #1; checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL target_match: got %b expected 0", mispredict); end
    set_ex(1'b1, 32'hFFFF_FFFC, 32'd7, 32'd7, 1'b1, 1'b0, 3'b001, 32'h40, 1'b0, 32'h0);
    if_pc = 32'hFFFF_FFFC;
    #1; checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL ex_pc_wrap: got %h expected 00000000", redirect_pc); end
    checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL if_pc_wrap: got %h expected 00000000", pred_target); end
    set_ex(1'b0, 32'h100, 32'd1, 32'd1, 1'b1, 1'b0, 3'b000, 32'h140, 1'b1, 32'h140);
    #1;
    checks++; if ({ex_taken, mispredict} !== 2'b00) begin errors++; $display("FAIL invalid_flags: got %b expected 00", {ex_taken, mispredict}); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL invalid_redirect: got %h expected 00000000", redirect_pc); end
    clear_ex();
  endtask

  task automatic test_alias();
    tick();
    // 0x100 ctr 01 -> 10
    set_ex(1'b1, 32'h100, 32'd1, 32'd1, 1'b1, 1'b0, 3'b000, 32'h140, 1'b0, 32'h104);
    tick();
    set_ex(1'b1, 32'h200, 32'd1, 32'd2, 1'b1, 1'b0, 3'b000, 32'h300, 1'b0, 32'h204);
    tick();
    clear_ex(); if_pc = 32'h100;
    #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alias_nt_keep: got %b expected 1", pred_taken); end
    checks++; if (pred_target !== 32'h140) begin errors++; $display("FAIL alias_nt_target: got %h expected 00000140", pred_target); end
    set_ex(1'b1, 32'h200, 32'd1, 32'd1, 1'b1, 1'b0, 3'b000, 32'h300, 1'b0, 32'h204);
    tick();
    clear_ex(); if_pc = 32'h100;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_evict: got %b expected 0", pred_taken); end
    if_pc = 32'h200;
    #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alias_new_pred: got %b expected 1", pred_taken); end
    checks++; if (pred_target !== 32'h300) begin errors++; $display("FAIL alias_new_target: got %h expected 00000300", pred_target); end
    checks++; if (perf_br_cnt !== 32'd7) begin errors++; $display("FAIL alias_perf_br: got %0d expected 7", perf_br_cnt); end
    checks++; if (perf_miss_cnt !== 32'd5) begin errors++; $display("FAIL alias_perf_miss: got %0d expected 5", perf_miss_cnt); end
    checks++; if (p_perf_miss_cnt !== 4'd5) begin errors++; $display("FAIL alias_perf4_miss: got %0d expected 5", p_perf_miss_cnt); end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1;
    set_ex(1'b1, 32'h180, 32'd5, 32'd5, 1'b1, 1'b0, 3'b000, 32'h1C0, 1'b0, 32'h184);
    #1;
    checks++; if (ex_taken !== 1'b1) begin errors++; $display("FAIL rst_comb_taken: got %b expected 1", ex_taken); end
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL rst_comb_mispredict: got %b expected 1", mispredict); end
    checks++; if (redirect_pc !== 32'h1C0) begin errors++; $display("FAIL rst_comb_redirect: got %h expected 000001c0", redirect_pc); end
    tick();
    rst = 1'b0; clear_ex(); if_pc = 32'h180;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_no_alloc: got %b expected 0", pred_taken); end
    checks++; if (pred_target !== 32'h184) begin errors++; $display("FAIL rst_no_alloc_target: got %h expected 00000184", pred_target); end
    checks++; if (perf_br_cnt !== 32'd0) begin errors++; $display("FAIL rst_perf_br: got %0d expected 0", perf_br_cnt); end
    checks++; if (perf_miss_cnt !== 32'd0) begin errors++; $display("FAIL rst_perf_miss: got %0d expected 0", perf_miss_cnt); end
    checks++; if (p_perf_br_cnt !== 4'd0) begin errors++; $display("FAIL rst_perf4_br: got %0d expected 0", p_perf_br_cnt); end
    if_pc = 32'h200;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_clears_btb: got %b expected 0", pred_taken); end
  endtask

  task automatic test_perf_saturation();
    for (int i = 0; i < 20; i++) begin
      set_ex(1'b1, 32'h500, 32'h0, 32'h0, 1'b0, 1'b1, 3'b000, 32'h600, 1'b0, 32'h504);
      tick();
    end
    clear_ex(); if_pc = 32'h500;
    #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL jal_pred: got %b expected 1", pred_taken); end
    checks++; if (pred_target !== 32'h600) begin errors++; $display("FAIL jal_target: got %h expected 00000600", pred_target); end
    checks++; if (perf_br_cnt !== 32'd20) begin errors++; $display("FAIL perf32_br: got %0d expected 20", perf_br_cnt); end
    checks++; if (perf_miss_cnt !== 32'd20) begin errors++; $display("FAIL perf32_miss: got %0d expected 20", perf_miss_cnt); end
    checks++; if (p_perf_br_cnt !== 4'd15) begin errors++; $display("FAIL perf4_br_sat: got %0d expected 15", p_perf_br_cnt); end
    checks++; if (p_perf_miss_cnt !== 4'd15) begin errors++; $display("FAIL perf4_miss_sat: got %0d expected 15", p_perf_miss_cnt); end
    // jump left ctr at 11, one not-taken leaves 10 (still taken)
    set_ex(1'b1, 32'h500, 32'd7, 32'd7, 1'b1, 1'b0, 3'b001, 32'h600, 1'b1, 32'h600);
    #1;
    checks++; if (redirect_pc !== 32'h504) begin errors++; $display("FAIL jal_nt_redirect: got %h expected 00000504", redirect_pc); end
    tick();
    clear_ex();
    #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL jal_ctr_sat: got %b expected 1", pred_taken); end
    checks++; if (perf_miss_cnt !== 32'd21) begin errors++; $display("FAIL perf32_miss_21: got %0d expected 21", perf_miss_cnt); end
    checks++; if (p_perf_miss_cnt !== 4'd15) begin errors++; $display("FAIL perf4_miss_hold: got %0d expected 15", p_perf_miss_cnt); end
  endtask

  initial begin
    test_reset();
    test_train_taken();
    test_back_to_back_untrain();
    test_conditions();
    test_alias();
    test_reset_priority();
    test_perf_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
